// File: rtl/fifo_push_arbiter.sv
// Packet-aware round-robin arbiter for a shared FIFO push port.
// Whole packets are granted, and new starts are throttled near full.
module fifo_push_arbiter #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int OCC_WIDTH  = 5,
    parameter int HIGH_WATER = 12,
    localparam int IW        = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [PORTS-1:0]            io_req_valid,
    output logic [PORTS-1:0]            io_req_ready,
    input  logic [PORTS*DATA_WIDTH-1:0] io_req_payload,
    input  logic [PORTS-1:0]            io_req_last,
    output logic                        io_out_valid,
    input  logic                        io_out_ready,
    output logic [DATA_WIDTH-1:0]       io_out_payload,
    output logic [IW-1:0]               io_out_source,
    input  logic [OCC_WIDTH-1:0]        io_occupancy,
    input  logic                        io_flush,
    output logic [PORTS-1:0]            io_grant,
    output logic                        io_throttled
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   lock_idx;
    logic [IW-1:0]   lock_idx_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   rr_ptr_nxt;
    logic [15:0]     packet_count;

    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic            below_hw;
    logic            gnt_active;
    logic [IW-1:0]   gnt_idx;
    logic [PORTS-1:0] gnt_vec;
    logic            fire;
    logic            fire_last;

    function automatic logic [IW-1:0] wrap_inc(
        input logic [IW-1:0] i
    );
        if (int'(i) == PORTS - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    assign below_hw =
        io_occupancy < OCC_WIDTH'(HIGH_WATER);

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        int p;
        sel_found = 1'b0;
        sel_idx   = '0;
        p         = 0;
        for (int k = 0; k < PORTS; k++) begin
            p = int'(rr_ptr) + k;
            if (p >= PORTS) begin
                p = p - PORTS;
            end
            if (!sel_found && io_req_valid[IW'(p)]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(p);
            end
        end
    end

    // Grant and datapath mux; reset and flush mask everything.
    always_comb begin
        gnt_active = 1'b0;
        gnt_idx    = '0;
        if (!reset && !io_flush) begin
            unique case (state)
                IDLE: begin
                    if (sel_found && below_hw) begin
                        gnt_active = 1'b1;
                        gnt_idx    = sel_idx;
                    end
                end
                LOCKED: begin
                    gnt_active = 1'b1;
                    gnt_idx    = lock_idx;
                end
                default: ;
            endcase
        end
        gnt_vec = '0;
        if (gnt_active) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
        io_grant       = gnt_vec;
        io_out_valid   = gnt_active && io_req_valid[gnt_idx];
        io_out_payload =
            io_req_payload[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        io_out_source  = gnt_idx;
        io_req_ready   = io_out_ready ? gnt_vec : '0;
        io_throttled   = !reset && (state == IDLE) && !below_hw;
        fire           = io_out_valid && io_out_ready;
        fire_last      = fire && io_req_last[gnt_idx];
    end

    // Next state: flush abandons any packet, transfers advance.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        lock_idx_nxt = lock_idx;
        if (io_flush) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = '0;
        end else if (fire) begin
            if (fire_last) begin
                state_nxt  = IDLE;
                rr_ptr_nxt = wrap_inc(gnt_idx);
            end else begin
                state_nxt    = LOCKED;
                lock_idx_nxt = gnt_idx;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            lock_idx     <= '0;
            packet_count <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            lock_idx <= lock_idx_nxt;
            if (fire_last) begin
                packet_count <= packet_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter.
// Inputs change after posedge; outputs checked at negedge.
module tb_fifo_push_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_payload;
    logic [3:0]  req_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_payload;
    logic [1:0]  out_source;
    logic [4:0]  occupancy;
    logic        flush;
    logic [3:0]  grant;
    logic        throttled;

    int checks = 0;
    int errors = 0;

    fifo_push_arbiter #(
        .PORTS(4),
        .DATA_WIDTH(8),
        .OCC_WIDTH(5),
        .HIGH_WATER(12)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_req_valid(req_valid),
        .io_req_ready(req_ready),
        .io_req_payload(req_payload),
        .io_req_last(req_last),
        .io_out_valid(out_valid),
        .io_out_ready(out_ready),
        .io_out_payload(out_payload),
        .io_out_source(out_source),
        .io_occupancy(occupancy),
        .io_flush(flush),
        .io_grant(grant),
        .io_throttled(throttled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 4'b1111;
        req_last    = 4'b1111;
        req_payload = 32'hD3C2B1A0;
        out_ready   = 1'b1;
        occupancy   = 5'd0;
        flush       = 1'b0;

        // reset held two cycles with all valids high
        smp();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_source", 32'(out_source), 0);
        chk("rst_thr", 32'(throttled), 0);
        cyc();
        smp();
        chk("rst2_grant", 32'(grant), 0);
        cyc();
        reset = 1'b0;

        // round robin single-word packets
        for (int k = 0; k < 6; k++) begin
            smp();
            chk("rr_source", 32'(out_source), k % 4);
            chk("rr_valid", 32'(out_valid), 1);
            if (k == 0) begin
                chk("rr_grant0", 32'(grant), 4'b0001);
                chk("rr_ready0", 32'(req_ready), 4'b0001);
            end
            cyc();
        end
        req_valid = 4'b0000;
        // rrPtr is now 2

        // packet lock: req0 3 words, req1 waiting
        req_valid = 4'b0011;
        req_last  = 4'b0010;
        req_payload[7:0] = 8'h11;
        smp();
        chk("lk_src1", 32'(out_source), 0);
        chk("lk_pay1", 32'(out_payload), 8'h11);
        chk("lk_gnt1", 32'(grant), 4'b0001);
        cyc();
        req_payload[7:0] = 8'h12;
        smp();
        chk("lk_src2", 32'(out_source), 0);
        chk("lk_pay2", 32'(out_payload), 8'h12);
        chk("lk_rdy2", 32'(req_ready), 4'b0001);
        cyc();
        req_valid = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            smp();
            chk("lk_gap_valid", 32'(out_valid), 0);
            chk("lk_gap_grant", 32'(grant), 4'b0001);
            cyc();
        end
        req_valid = 4'b0011;
        req_last  = 4'b0011;
        req_payload[7:0] = 8'h13;
        smp();
        chk("lk_src3", 32'(out_source), 0);
        chk("lk_pay3", 32'(out_payload), 8'h13);
        chk("lk_val3", 32'(out_valid), 1);
        cyc();
        smp();
        chk("lk_next_src", 32'(out_source), 1);
        chk("lk_next_gnt", 32'(grant), 4'b0010);
        chk("lk_next_pay", 32'(out_payload), 8'hB1);
        cyc();
        req_valid = 4'b0000;
        // rrPtr is now 2

        // throttle boundaries
        occupancy = 5'd11;
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        smp();
        chk("th11_valid", 32'(out_valid), 1);
        chk("th11_grant", 32'(grant), 4'b0001);
        chk("th11_thr", 32'(throttled), 0);
        cyc();
        occupancy = 5'd12;
        req_last  = 4'b0001;
        smp();
        chk("thlk_valid", 32'(out_valid), 1);
        chk("thlk_src", 32'(out_source), 0);
        chk("thlk_thr", 32'(throttled), 0);
        cyc();
        req_valid = 4'b0011;
        req_last  = 4'b0011;
        smp();
        chk("th12_valid", 32'(out_valid), 0);
        chk("th12_grant", 32'(grant), 0);
        chk("th12_ready", 32'(req_ready), 0);
        chk("th12_thr", 32'(throttled), 1);
        cyc();
        occupancy = 5'd11;
        smp();
        chk("threl_valid", 32'(out_valid), 1);
        chk("threl_src", 32'(out_source), 1);
        chk("threl_thr", 32'(throttled), 0);
        cyc();
        req_valid = 4'b0000;
        occupancy = 5'd0;
        // rrPtr is now 2

        // flush mid-packet
        req_valid = 4'b0101;
        req_last  = 4'b0001;
        smp();
        chk("fl_src", 32'(out_source), 2);
        cyc();
        flush = 1'b1;
        smp();
        chk("fl_ready", 32'(req_ready), 0);
        chk("fl_grant", 32'(grant), 0);
        chk("fl_valid", 32'(out_valid), 0);
        cyc();
        flush = 1'b0;
        smp();
        chk("fl_after_gnt", 32'(grant), 4'b0001);
        chk("fl_after_src", 32'(out_source), 0);
        cyc();
        // rrPtr is now 1

        // backpressure on req3 with req0 also valid
        req_valid = 4'b1001;
        req_last  = 4'b0001;
        req_payload[31:24] = 8'h33;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("bp_grant", 32'(grant), 4'b1000);
            chk("bp_src", 32'(out_source), 3);
            chk("bp_pay", 32'(out_payload), 8'h33);
            chk("bp_ready", 32'(req_ready), 0);
            chk("bp_valid", 32'(out_valid), 1);
            cyc();
        end
        out_ready = 1'b1;
        smp();
        chk("bp_rel_ready", 32'(req_ready), 4'b1000);
        cyc();
        req_last = 4'b1001;
        req_payload[31:24] = 8'h34;
        smp();
        chk("bp_w2_src", 32'(out_source), 3);
        chk("bp_w2_pay", 32'(out_payload), 8'h34);
        cyc();
        smp();
        chk("bp_next_src", 32'(out_source), 0);
        chk("bp_next_gnt", 32'(grant), 4'b0001);
        cyc();

        // reset mid-packet discards the lock
        req_valid = 4'b0110;
        req_last  = 4'b0000;
        smp();
        chk("rm_src", 32'(out_source), 1);
        cyc();
        reset = 1'b1;
        smp();
        chk("rm_grant", 32'(grant), 0);
        cyc();
        reset = 1'b0;
        req_valid = 4'b0100;
        smp();
        chk("rm_after_gnt", 32'(grant), 4'b0100);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
